prco_fetch: RTL
===============

# prco_fetch

Instruction fetch stage of the PRCO core, sitting directly upstream of the decoder. It holds the program counter and reads 16-bit instruction words from instruction memory over a req/ack handshake. Each fetched word is presented to the decoder with a one-cycle `q_ce` strobe. A new fetch starts on a `i_fetch` pulse, driven by the decoder's fetch request or by pipeline completion. Jump redirects from the execute stage are accepted at any time.

## Interface
- `ADDR_W`, 16: width of PC and instruction memory word address.
- `RESET_PC`, 0: PC value after reset; first instruction fetched from here.

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  reset; one clock, synchronous and active-high.
- `i_en`  in  1  enable; when low, no new fetch is started; a handshake already in progress still completes.
- `i_fetch`  in  1  single-cycle pulse requesting the next instruction.
- `i_jmp_en`  in  1  single-cycle pulse to redirect the PC.
- `i_jmp_addr`  in  ADDR_W  jump target, valid with `i_jmp_en`.
- `q_mem_req`  out  1  instruction memory read request.
- `q_mem_addr`  out  ADDR_W  read address; stable while `q_mem_req` is high.
- `i_mem_ack`  in  1  one-cycle pulse: `i_mem_data` is valid and the request has ended.
- `i_mem_data`  in  16  instruction word.
- `q_instr`  out  16  fetched instruction; connects to decoder `i_instr`.
- `q_ce`  out  1  one-cycle strobe marking `q_instr` valid; connects to decoder `i_ce`.
- `q_pc`  out  ADDR_W  address of the word currently in `q_instr`.
- `q_busy`  out  1  high whenever state is not S_IDLE.

## Operation
- Registers:
  - `pc` (next fetch address)
  - `q_mem_addr`
  - `q_instr`
  - `q_pc`
  - `kill` flag (current request was overtaken by a jump)
  - `pend` flag (an `i_fetch` arrived while busy)
- Reset values:
  - state = S_BOOT
  - `pc` = `q_mem_addr` = `q_pc` = `RESET_PC`
  - `q_instr` = 16'h0000 (NOP encoding)
  - `q_ce` = 0, `q_mem_req` = 0
  - `kill` = 0, `pend` = 0
  - `q_busy` = 1, because the state is S_BOOT.
- States:
  - S_BOOT: if `i_en` is high, `q_mem_addr <= pc` and go to S_REQ. Otherwise hold.
  - S_IDLE: on `i_fetch` or `pend` with `i_en` high, `q_mem_addr <= pc`, clear `pend`, go to S_REQ. With `i_en` low, an `i_fetch` pulse sets `pend`.
  - S_REQ: `q_mem_req` = 1 and `q_mem_addr` is held. On `i_mem_ack`:
    - if `kill` is clear and there is no same-cycle `i_jmp_en`: `q_instr <= i_mem_data`, `q_pc <= q_mem_addr`, `pc <= q_mem_addr + 1` (mod 2^ADDR_W), go to S_ISSUE.
    - otherwise: discard the data, clear `kill`, `q_mem_addr <= pc` (the jump target), and stay in S_REQ. The next cycle is a new request.
  - S_ISSUE: `q_ce` = 1 for exactly this cycle. Then go to S_REQ if `pend` is set and `i_en` is high (setting `q_mem_addr <= pc` and clearing `pend`). Otherwise go to S_IDLE.
- Jump handling:
  - `i_jmp_en` in any state except reset sets `pc <= i_jmp_addr`. A jump overrides the +1 increment.
  - In S_REQ without a same-cycle ack, a jump also sets `kill`.
  - In S_IDLE with `i_fetch` in the same cycle, the request goes to `i_jmp_addr` directly (bypass).
  - In S_ISSUE, the current `q_instr`/`q_ce` are still delivered.
- `i_fetch` while in S_BOOT, S_REQ or S_ISSUE sets `pend`. Multiple pulses collapse into one.
- `q_mem_req` drops only after an ack cycle that moves the state to S_ISSUE, or after reset.
- `q_instr` and `q_pc` hold their values until the next accepted ack.

## Timing
- `i_fetch` in S_IDLE at cycle N → `q_mem_req` high from N+1.
- Ack at cycle M ≥ N+1 → `q_ce` = 1 and `q_instr` valid at M+1 → S_IDLE at M+2.
- With a zero-wait memory (ack in the first request cycle), fetch-to-`q_ce` latency is 2 cycles.
- After reset deasserts, the first cycle is S_BOOT and the first request is on the next cycle.
- Reset asserted mid-handshake: all registers return to their reset values on the next edge. A late `i_mem_ack` arriving while in S_BOOT or S_IDLE is ignored.
- PC wraps from 2^ADDR_W−1 to 0 without any flag.

## Test plan
- Reset release, `i_en`=1, memory acks in the first request cycle with 16'h0801 → `q_mem_addr`=0 requested at cycle 1; `q_ce` pulses with `q_instr`=16'h0801, `q_pc`=0; then idle with `pc`=1.
- `i_fetch` in S_IDLE, memory waits 3 cycles before ack → `q_mem_req`/`q_mem_addr`=1 stay stable 4 cycles; `q_ce` is exactly one cycle, the cycle after ack.
- `i_jmp_en` with `i_jmp_addr`=16'h0040 two cycles into a pending request → first ack data is discarded with no `q_ce`; a new request goes to 16'h0040; `q_pc`=16'h0040 at `q_ce`.
- `i_fetch` pulsed twice during S_REQ → exactly one further fetch follows S_ISSUE directly (no S_IDLE cycle).
- Jump and `i_fetch` in the same S_IDLE cycle with target 16'h0100 → the request address is 16'h0100.
- `pc`=16'hFFFF fetched → `pc` wraps to 0. Separately, `i_reset` asserted during a wait state → `q_mem_req`=0, `q_ce`=0, and the state returns to S_BOOT on the next edge.

Source files
------------

// File: rtl/prco_fetch.sv
// prco_fetch: instruction fetch stage of the PRCO core.
// Holds the program counter, reads 16-bit words over a req/ack handshake
// and hands each word to the decoder with a one-cycle q_ce strobe.
module prco_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_fetch,
    input  logic              i_jmp_en,
    input  logic [ADDR_W-1:0] i_jmp_addr,
    output logic              q_mem_req,
    output logic [ADDR_W-1:0] q_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_data,
    output logic [15:0]       q_instr,
    output logic              q_ce,
    output logic [ADDR_W-1:0] q_pc,
    output logic              q_busy
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_IDLE  = 2'd1,
        S_REQ   = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t            state_reg,  state_next;
    logic [ADDR_W-1:0] pc_reg,     pc_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic [15:0]       instr_reg,  instr_next;
    logic [ADDR_W-1:0] qpc_reg,    qpc_next;
    logic              kill_reg,   kill_next;
    logic              pend_reg,   pend_next;

    // Address a new request should use: a same-cycle jump bypasses pc_reg
    // so the redirect takes effect without an extra cycle.
    logic [ADDR_W-1:0] pc_eff;
    assign pc_eff = i_jmp_en ? i_jmp_addr : pc_reg;

    // Next-state and register-update logic for the fetch handshake.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        instr_next = instr_reg;
        qpc_next   = qpc_reg;
        kill_next  = kill_reg;
        pend_next  = pend_reg | i_fetch;   // fetch pulses collapse into one

        if (i_jmp_en) begin
            pc_next = i_jmp_addr;
        end

        case (state_reg)
            S_BOOT: begin
                if (i_en) begin
                    addr_next  = pc_eff;
                    state_next = S_REQ;
                end
            end
            S_IDLE: begin
                if (i_en && (i_fetch || pend_reg)) begin
                    addr_next  = pc_eff;
                    pend_next  = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    if (!kill_reg && !i_jmp_en) begin
                        instr_next = i_mem_data;
                        qpc_next   = addr_reg;
                        pc_next    = addr_reg + 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        // Stale word: drop it and re-issue at the jump target.
                        kill_next = 1'b0;
                        addr_next = pc_eff;
                    end
                end else if (i_jmp_en) begin
                    kill_next = 1'b1;
                end
            end
            S_ISSUE: begin
                if (pend_reg && i_en) begin
                    addr_next  = pc_eff;
                    pend_next  = i_fetch;
                    state_next = S_REQ;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= S_BOOT;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            instr_reg <= 16'h0000;
            qpc_reg   <= RESET_PC;
            kill_reg  <= 1'b0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            instr_reg <= instr_next;
            qpc_reg   <= qpc_next;
            kill_reg  <= kill_next;
            pend_reg  <= pend_next;
        end
    end

    assign q_mem_req  = (state_reg == S_REQ);
    assign q_ce       = (state_reg == S_ISSUE);
    assign q_busy     = (state_reg != S_IDLE);
    assign q_mem_addr = addr_reg;
    assign q_instr    = instr_reg;
    assign q_pc       = qpc_reg;

endmodule
